// File: rtl/tdm_demux_4x1.sv
// tdm_demux_4x1: receive side of a 4-slot TDM serial link.
// Recovers slot timing from a frame sync strobe and samples din once per slot.
// Publishes a/b/c/d together at each frame boundary with a one-cycle valid pulse.
module tdm_demux_4x1 #(
  parameter int SLOT_CYCLES  = 4,
  parameter int SAMPLE_POINT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       sync,
  input  logic       din,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [1:0] sel,
  output logic       frame_valid,
  output logic       locked,
  output logic       sync_err
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(SAMPLE_POINT);
  localparam bit SAMPLE_AT_ORIGIN = (SAMPLE_POINT == 0);

  // Position of the cycle that follows a sync-aligned (0,0) cycle.
  localparam logic [CW-1:0] RESTART_CYC  = (SLOT_CYCLES == 1) ? CW'(0) : CW'(1);
  localparam logic [1:0]    RESTART_SLOT = (SLOT_CYCLES == 1) ? 2'd1 : 2'd0;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [1:0]    slot_q, slot_d;
  logic [3:0]    shadow_q, shadow_d;
  logic [3:0]    out_q, out_d;
  logic          frame_valid_q, frame_valid_d;
  logic          sync_err_q, sync_err_d;

  logic          at_origin;
  logic          at_frame_end;

  assign at_origin    = (slot_q == 2'd0) && (cyc_q == '0);
  assign at_frame_end = (slot_q == 2'd3) && (cyc_q == CYC_LAST);

  // Next-state logic: slot tracking, sampling, publication and sync checking.
  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    out_d         = out_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (enable) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            if (SAMPLE_AT_ORIGIN) shadow_d[0] = din;
            cyc_d   = RESTART_CYC;
            slot_d  = RESTART_SLOT;
            state_d = LOCKED;
          end
        end

        LOCKED: begin
          if (sync && !at_origin) begin
            // Misplaced sync: realign on it and abandon the partial frame.
            sync_err_d = 1'b1;
            if (SAMPLE_AT_ORIGIN) shadow_d[0] = din;
            cyc_d  = RESTART_CYC;
            slot_d = RESTART_SLOT;
          end else if (!sync && at_origin) begin
            // Missing sync: lose lock, keep the last published frame.
            sync_err_d = 1'b1;
            state_d    = HUNT;
            cyc_d      = '0;
            slot_d     = 2'd0;
          end else begin
            if (cyc_q == SAMPLE_AT) shadow_d[slot_q] = din;
            if (at_frame_end) begin
              out_d         = shadow_d;
              frame_valid_d = 1'b1;
            end
            if (cyc_q == CYC_LAST) begin
              cyc_d  = '0;
              slot_d = slot_q + 2'd1;
            end else begin
              cyc_d = cyc_q + CW'(1);
            end
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= HUNT;
      cyc_q         <= '0;
      slot_q        <= 2'd0;
      shadow_q      <= 4'd0;
      out_q         <= 4'd0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      out_q         <= out_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign a           = out_q[0];
  assign b           = out_q[1];
  assign c           = out_q[2];
  assign d           = out_q[3];
  assign sel         = slot_q;
  assign locked      = (state_q == LOCKED);
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;

endmodule
